// File: rtl/matrix_input_parser_if.sv
// Bus bundle between the matrix input parser and its neighbours.
// Covers the menu controller control/status pins, the UART receive byte
// stream and the matrix_storage write port.
interface matrix_input_parser_if;
  logic         start;
  logic         busy;
  logic         done;
  logic         error;
  logic [1:0]   err_code;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         write_en;
  logic [2:0]   dimM;
  logic [2:0]   dimN;
  logic [199:0] wr_data_flow;
  logic         wr_ready;

  // Parser side.
  modport master (
    input  start, rx_valid, rx_data, wr_ready,
    output busy, done, error, err_code, write_en, dimM, dimN, wr_data_flow
  );

  // Controller / UART / storage side.
  modport slave (
    output start, rx_valid, rx_data, wr_ready,
    input  busy, done, error, err_code, write_en, dimM, dimN, wr_data_flow
  );
endinterface

// File: rtl/matrix_input_parser.sv
// ASCII matrix parser: "m n e0 e1 ... e(m*n-1)" from uart_rx, packed into
// 25 byte slots and handed to matrix_storage with a write_en/wr_ready
// handshake. Reports done or a coded error to the menu controller.
module matrix_input_parser (
  input  logic                  clk,
  input  logic                  rst,
  matrix_input_parser_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, PARSE_M, PARSE_N, PARSE_ELEM, WRITE_REQ, WRITE_WAIT, DONE, ERROR
  } state_t;

  state_t     state;
  logic [9:0] acc;     // token value; 10 bits holds up to 999
  logic [1:0] ndig;    // digits seen in the current token
  logic [4:0] k;       // next element slot
  logic [4:0] total;   // m*n

  logic       parsing, is_digit, is_sep, dim_ok, fail;
  logic [1:0] fail_code;
  logic [9:0] acc_next;

  // Byte classification and abort detection for the byte sampled this edge.
  always_comb begin
    parsing   = (state == PARSE_M) || (state == PARSE_N) || (state == PARSE_ELEM);
    is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_sep    = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    // acc is at most 99 whenever a digit is accepted, so this never wraps.
    acc_next  = (acc << 3) + (acc << 1) + {6'd0, bus.rx_data[3:0]};
    dim_ok    = (acc >= 10'd1) && (acc <= 10'd5);
    fail      = 1'b0;
    fail_code = 2'd0;
    if (parsing && bus.rx_valid) begin
      if (is_digit) begin
        if (ndig == 2'd3) begin
          fail      = 1'b1;
          fail_code = (state == PARSE_ELEM) ? 2'd3 : 2'd2;
        end
      end else if (!is_sep) begin
        fail      = 1'b1;
        fail_code = 2'd1;
      end else if (ndig != 2'd0) begin
        if (state != PARSE_ELEM && !dim_ok) begin
          fail      = 1'b1;
          fail_code = 2'd2;
        end else if (state == PARSE_ELEM && acc > 10'd255) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      acc              <= '0;
      ndig             <= '0;
      k                <= '0;
      total            <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.err_code     <= '0;
      bus.write_en     <= 1'b0;
      bus.dimM         <= '0;
      bus.dimN         <= '0;
      bus.wr_data_flow <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state            <= PARSE_M;
            bus.busy         <= 1'b1;
            acc              <= '0;
            ndig             <= '0;
            k                <= '0;
            bus.wr_data_flow <= '0;
            bus.err_code     <= '0;
          end
        end
        PARSE_M, PARSE_N, PARSE_ELEM: begin
          if (fail) begin
            state        <= ERROR;
            bus.error    <= 1'b1;
            bus.busy     <= 1'b0;
            bus.err_code <= fail_code;
          end else if (bus.rx_valid) begin
            if (is_digit) begin
              acc  <= acc_next;
              ndig <= ndig + 2'd1;
            end else if (ndig != 2'd0) begin
              // separator closes the pending token
              acc  <= '0;
              ndig <= '0;
              if (state == PARSE_M) begin
                bus.dimM <= acc[2:0];
                state    <= PARSE_N;
              end else if (state == PARSE_N) begin
                bus.dimN <= acc[2:0];
                total    <= {2'b00, bus.dimM} * {2'b00, acc[2:0]};
                state    <= PARSE_ELEM;
              end else begin
                bus.wr_data_flow[{k, 3'b000} +: 8] <= acc[7:0];
                k <= k + 5'd1;
                if (k + 5'd1 == total)
                  state <= WRITE_REQ;
              end
            end
          end
        end
        WRITE_REQ: begin
          bus.write_en <= 1'b1;
          state        <= WRITE_WAIT;
        end
        WRITE_WAIT: begin
          if (bus.wr_ready) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        DONE, ERROR: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end
endmodule
